// File: rtl/down_count_monitor_if.sv
// +----------------------------------------------------------------------------+
// | Module : down_count_monitor_if                                             |
// | Brief  : Count-bus / control / status bundle for down_count_monitor.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface down_count_monitor_if #(
    parameter int WIDTH  = 2,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]      cnt_in;
    logic                  cnt_valid;
    logic                  err_clr;
    logic                  wrap_clr;
    logic [(2**WIDTH)-1:0] onehot_out;
    logic                  tc_pulse;
    logic [WRAP_W-1:0]     wrap_cnt;
    logic                  locked;
    logic                  seq_err;

    // Upstream counter / control side
    modport master (
        output cnt_in, cnt_valid, err_clr, wrap_clr,
        input  onehot_out, tc_pulse, wrap_cnt, locked, seq_err
    );

    // Monitor side
    modport slave (
        input  cnt_in, cnt_valid, err_clr, wrap_clr,
        output onehot_out, tc_pulse, wrap_cnt, locked, seq_err
    );
endinterface

`default_nettype wire

// File: rtl/down_count_monitor.sv
// +----------------------------------------------------------------------------+
// | Module : down_count_monitor                                                |
// | Brief  : One-hot decode, terminal-count / wrap flags and a lock/track/     |
// |          error FSM checking that a down counter steps by exactly -1.       |
// |          Define DCM_ONEHOT_REG_EN to register onehot_out (1-cycle latency).|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module down_count_monitor #(
    parameter int WIDTH  = 2,
    parameter int WRAP_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    down_count_monitor_if.slave   bus
);

    localparam int                c_ONEHOT_W = 2**WIDTH;
    localparam logic [WRAP_W-1:0] c_WRAP_MAX = '1;

    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_TRACK    = 2'd1;
    localparam logic [1:0] c_ST_ERROR    = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [WIDTH-1:0]      r_prev;
    logic                  w_match;
    logic                  w_track_hit;
    logic                  w_tc_set;
    logic                  w_wrap_inc;
    logic                  w_locked;
    logic                  w_seq_err;
    logic                  r_tc;
    logic [WRAP_W-1:0]     r_wrap;
    logic [c_ONEHOT_W-1:0] w_onehot;

    // The mod-2^WIDTH subtraction makes 0 -> MAX a legal step
    assign w_match = (bus.cnt_in == (r_prev - WIDTH'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_UNLOCKED: begin
                if (bus.cnt_valid) begin
                    w_state_nxt = c_ST_TRACK;
                end
            end
            c_ST_TRACK: begin
                // A mismatch wins over a same-cycle err_clr
                if (bus.cnt_valid && !w_match) begin
                    w_state_nxt = c_ST_ERROR;
                end
            end
            c_ST_ERROR: begin
                if (bus.err_clr) begin
                    w_state_nxt = c_ST_UNLOCKED;
                end
            end
            default: w_state_nxt = c_ST_UNLOCKED;
        endcase
    end

    always_comb begin
        w_locked    = (r_state == c_ST_TRACK);
        w_seq_err   = (r_state == c_ST_ERROR);
        w_track_hit = w_locked && bus.cnt_valid && w_match;
        w_tc_set    = w_track_hit && (bus.cnt_in == '0);
        w_wrap_inc  = w_track_hit && (r_prev == '0) && (r_wrap != c_WRAP_MAX);
    end

    // prev follows every valid sample, whatever the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else if (bus.cnt_valid) begin
            r_prev <= bus.cnt_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_tc_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= '0;
        end else if (bus.wrap_clr) begin
            r_wrap <= '0;
        end else if (w_wrap_inc) begin
            r_wrap <= r_wrap + WRAP_W'(1);
        end
    end

    always_comb begin
        w_onehot              = '0;
        w_onehot[bus.cnt_in]  = 1'b1;
    end

`ifdef DCM_ONEHOT_REG_EN
    logic [c_ONEHOT_W-1:0] r_onehot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehot <= '0;
        end else begin
            r_onehot <= w_onehot;
        end
    end

    assign bus.onehot_out = r_onehot;
`else
    assign bus.onehot_out = w_onehot;
`endif

    assign bus.tc_pulse = r_tc;
    assign bus.wrap_cnt = r_wrap;
    assign bus.locked   = w_locked;
    assign bus.seq_err  = w_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_down_count_monitor.sv
// +----------------------------------------------------------------------------+
// | Module : tb_down_count_monitor                                             |
// | Brief  : Directed bench for down_count_monitor with a spec-level model.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_down_count_monitor;

    localparam int WIDTH    = 2;
    localparam int WRAP_W   = 8;
    localparam int CNT_MOD  = 4;
    localparam int WRAP_SAT = 255;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    down_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus();

    down_count_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 = waiting for first sample, 1 = tracking, 2 = error latched
    int m_mode;
    int m_prev;
    int m_wrap;
    bit m_tc;
    int m_oh_q;
    bit m_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_prev = 0;
            m_wrap = 0;
            m_tc   = 1'b0;
            m_oh_q = 0;
        end else begin
            m_hit = (m_mode == 1) && bus.cnt_valid &&
                    (int'(bus.cnt_in) == (m_prev + CNT_MOD - 1) % CNT_MOD);
            m_tc  = m_hit && (bus.cnt_in == 0);
            if (bus.wrap_clr)
                m_wrap = 0;
            else if (m_hit && m_prev == 0 && m_wrap < WRAP_SAT)
                m_wrap = m_wrap + 1;
            if (m_mode == 0 && bus.cnt_valid)
                m_mode = 1;
            else if (m_mode == 1 && bus.cnt_valid && !m_hit)
                m_mode = 2;
            else if (m_mode == 2 && bus.err_clr)
                m_mode = 0;
            if (bus.cnt_valid)
                m_prev = int'(bus.cnt_in);
            m_oh_q = 1 << bus.cnt_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",   32'(bus.locked),   32'(m_mode == 1));
            check("seq_err",  32'(bus.seq_err),  32'(m_mode == 2));
            check("tc_pulse", 32'(bus.tc_pulse), 32'(m_tc));
            check("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_wrap));
`ifdef DCM_ONEHOT_REG_EN
            check("onehot",   32'(bus.onehot_out), 32'(m_oh_q));
`else
            check("onehot",   32'(bus.onehot_out), 32'(1) << bus.cnt_in);
`endif
        end
    end

    // Inputs change just after the falling edge; outputs of that sample are
    // visible when the following cyc() call returns.
    task automatic cyc(input bit v, input int c, input bit ec, input bit wc);
        @(negedge clk);
        #1;
        bus.cnt_valid = v;
        bus.cnt_in    = WIDTH'(c);
        bus.err_clr   = ec;
        bus.wrap_clr  = wc;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cnt_valid = 1'b0;
        bus.cnt_in    = '0;
        bus.err_clr   = 1'b0;
        bus.wrap_clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("t1_rst_locked", 32'(bus.locked),   32'd0);
        check("t1_rst_wrap",   32'(bus.wrap_cnt), 32'd0);
`ifdef DCM_ONEHOT_REG_EN
        check("t1_rst_onehot", 32'(bus.onehot_out), 32'd0);
`else
        check("t1_rst_onehot", 32'(bus.onehot_out), 32'b0001);
`endif
        @(negedge clk);
        #1;
        rst = 1'b0;

        // 1: idle after reset
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t1_locked",  32'(bus.locked),   32'd0);
        check("t1_seq_err", 32'(bus.seq_err),  32'd0);
        check("t1_tc",      32'(bus.tc_pulse), 32'd0);

        // 2: legal sequence 3,2,1,0,3,2
        cyc(1, 3, 0, 0);
        cyc(1, 2, 0, 0);
        check("t2_locked", 32'(bus.locked), 32'd1);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 3, 0, 0);
        check("t2_tc_on_0", 32'(bus.tc_pulse), 32'd1);
        cyc(1, 2, 0, 0);
        check("t2_tc_once", 32'(bus.tc_pulse), 32'd0);
        check("t2_wrap1",   32'(bus.wrap_cnt), 32'd1);
        cyc(0, 2, 0, 0);
        check("t2_seq_err", 32'(bus.seq_err), 32'd0);

        // 3: skip 2 -> 0, error latched, then clear and relock
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("t3_seq_err", 32'(bus.seq_err), 32'd1);
        check("t3_unlock",  32'(bus.locked),  32'd0);
        cyc(1, 3, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 3, 0, 0);
        check("t3_no_tc",   32'(bus.tc_pulse), 32'd0);
        cyc(0, 3, 0, 0);
        check("t3_no_wrap", 32'(bus.wrap_cnt), 32'd1);
        cyc(0, 3, 1, 0);
        cyc(0, 3, 0, 0);
        check("t3_clr_err", 32'(bus.seq_err), 32'd0);
        check("t3_clr_unl", 32'(bus.locked),  32'd0);
        cyc(1, 2, 0, 0);
        cyc(1, 1, 0, 0);
        check("t3_relock", 32'(bus.locked), 32'd1);
        cyc(0, 1, 0, 0);

        // simultaneous: mismatch + err_clr in TRACK, then err_clr + valid in ERROR
        cyc(1, 3, 1, 0);
        cyc(1, 2, 1, 0);
        check("sim_err_wins", 32'(bus.seq_err), 32'd1);
        cyc(1, 0, 0, 0);
        check("sim_unlocked", 32'(bus.locked), 32'd0);
        cyc(1, 3, 0, 0);
        check("sim_relock", 32'(bus.locked),   32'd1);
        check("sim_no_tc",  32'(bus.tc_pulse), 32'd0);
        cyc(0, 3, 0, 0);
        check("sim_wrap2", 32'(bus.wrap_cnt), 32'd2);

        // 4: saturation, then wrap_clr against a wrap edge
        for (int i = 0; i < 300; i++) begin
            cyc(1, 2, 0, 0);
            cyc(1, 1, 0, 0);
            cyc(1, 0, 0, 0);
            cyc(1, 3, 0, 0);
        end
        cyc(0, 3, 0, 0);
        check("t4_sat", 32'(bus.wrap_cnt), 32'd255);
        cyc(1, 2, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 3, 0, 1);
        cyc(0, 3, 0, 0);
        check("t4_clr_prio", 32'(bus.wrap_cnt), 32'd0);

        // 5: valid toggling around 1,(hold),0
        cyc(1, 2, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("t5_tc_on_1",    32'(bus.tc_pulse), 32'd0);
        cyc(1, 0, 0, 0);
        check("t5_tc_on_hold", 32'(bus.tc_pulse), 32'd0);
        cyc(0, 0, 0, 0);
        check("t5_tc_on_0",    32'(bus.tc_pulse), 32'd1);
        check("t5_no_err",     32'(bus.seq_err),  32'd0);
        cyc(0, 0, 0, 0);
        check("t5_tc_off",     32'(bus.tc_pulse), 32'd0);

        // 6: asynchronous reset mid-sequence with cnt_in=1
        cyc(1, 3, 0, 0);
        cyc(1, 2, 0, 0);
        check("t6_wrap_pre", 32'(bus.wrap_cnt), 32'd1);
        cyc(1, 1, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_locked", 32'(bus.locked),   32'd0);
        check("t6_rst_wrap",   32'(bus.wrap_cnt), 32'd0);
        check("t6_rst_tc",     32'(bus.tc_pulse), 32'd0);
`ifdef DCM_ONEHOT_REG_EN
        check("t6_rst_onehot", 32'(bus.onehot_out), 32'd0);
`else
        check("t6_onehot_1",   32'(bus.onehot_out), 32'b0010);
`endif
        @(negedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        check("t6_relock", 32'(bus.locked), 32'd1);
`ifdef DCM_ONEHOT_REG_EN
        check("t6_onehot_1", 32'(bus.onehot_out), 32'b0010);
`endif
        cyc(0, 0, 0, 0);
        check("t6_tc", 32'(bus.tc_pulse), 32'd1);
        cyc(0, 0, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
